sine_rom_scheduler: RTL and testbench

- Sequences and shares the single synchronous 64x32 sine ROM between two playback channels.
- Each channel owns a phase accumulator with its own tuning step.
- On every accepted sample tick (100 kHz TickCounter strobe), the block issues two back-to-back ROM reads, channel 0 first and then channel 1. It captures each word and presents it with a one-cycle valid pulse.
- Sits between TickCounter and ROM in the sine-wave top level, replacing the free-running pointer counter.

---
 rtl/sine_rom_scheduler.sv | 108 ++++++++++
 tb/tb_sine_rom_scheduler.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sine_rom_scheduler.sv
// Shares one synchronous sine ROM between two phase-accumulator playback channels.
// Optional channel-1 phase offset port is enabled with SINE_ROM_SCHED_PHASE_OFFSET_EN.
//
// state | meaning
// IDLE  | waiting for an enabled tick
// RD0   | channel 0 address on the ROM bus
// RD1   | channel 1 address on the ROM bus, channel 0 word arriving
// CAP1  | channel 1 word arriving
module sine_rom_scheduler #(
   parameter int ADDR_WIDTH  = 6,
   parameter int DATA_WIDTH  = 32,
   parameter int PHASE_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   tick,
   input  logic                   enable,
   input  logic [PHASE_WIDTH-1:0] step0,
   input  logic [PHASE_WIDTH-1:0] step1,
`ifdef SINE_ROM_SCHED_PHASE_OFFSET_EN
   input  logic [PHASE_WIDTH-1:0] phase_off1,
`endif
   output logic                   rom_en,
   output logic [ADDR_WIDTH-1:0]  rom_addr,
   input  logic [DATA_WIDTH-1:0]  rom_data,
   output logic [DATA_WIDTH-1:0]  ch0_data,
   output logic                   ch0_valid,
   output logic [DATA_WIDTH-1:0]  ch1_data,
   output logic                   ch1_valid,
   output logic                   busy,
   output logic                   overrun
);

   localparam int PW = PHASE_WIDTH;
   localparam int AW = ADDR_WIDTH;

   typedef enum logic [1:0] {IDLE, RD0, RD1, CAP1} state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] acc0, acc1, phase1;
   logic [AW-1:0] addr1_q;
   logic          start, drop;

`ifdef SINE_ROM_SCHED_PHASE_OFFSET_EN
   assign phase1 = acc1 + phase_off1;
`else
   assign phase1 = acc1;
`endif

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (tick && enable) state_d = RD0;
         RD0:     state_d = RD1;
         RD1:     state_d = CAP1;
         CAP1:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy  = (state_q != IDLE);
      start = (state_q == IDLE) && tick && enable;
      drop  = (state_q != IDLE) && tick && enable;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc0      <= '0;
         acc1      <= '0;
         addr1_q   <= '0;
         rom_en    <= 1'b0;
         rom_addr  <= '0;
         ch0_data  <= '0;
         ch1_data  <= '0;
         ch0_valid <= 1'b0;
         ch1_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         ch0_valid <= 1'b0;
         ch1_valid <= 1'b0;
         rom_en    <= start || (state_q == RD0);
         if (drop) overrun <= 1'b1;
         if (start) begin
            // Addresses come from the pre-increment phase, so the first tick reads 0.
            rom_addr <= acc0[PW-1:PW-AW];
            addr1_q  <= phase1[PW-1:PW-AW];
            acc0     <= acc0 + step0;
            acc1     <= acc1 + step1;
         end
         if (state_q == RD0) rom_addr <= addr1_q;
         if (state_q == RD1) begin
            ch0_data  <= rom_data;
            ch0_valid <= 1'b1;
         end
         if (state_q == CAP1) begin
            ch1_data  <= rom_data;
            ch1_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sine_rom_scheduler.sv
// Randomized self-checking bench for sine_rom_scheduler against a phase-arithmetic model.
// Build with SINE_ROM_SCHED_PHASE_OFFSET_EN to exercise the channel-1 offset port.
module tb_sine_rom_scheduler;

   localparam int AW = 6;
   localparam int DW = 32;
   localparam int PW = 16;
   localparam int SH = PW - AW;
   localparam int PMASK = (1 << PW) - 1;

   logic          clk;
   logic          rst;
   logic          tick;
   logic          enable;
   logic [PW-1:0] step0, step1;
`ifdef SINE_ROM_SCHED_PHASE_OFFSET_EN
   logic [PW-1:0] phase_off1;
`endif
   logic          rom_en;
   logic [AW-1:0] rom_addr;
   logic [DW-1:0] rom_data = '0;
   logic [DW-1:0] ch0_data, ch1_data;
   logic          ch0_valid, ch1_valid, busy, overrun;

   int n_checks = 0;
   int n_errs   = 0;
   int m_acc0 = 0, m_acc1 = 0, m_off = 0;
   int n_romen = 0, n_v0 = 0, n_v1 = 0, n_busy = 0;

   sine_rom_scheduler #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PHASE_WIDTH(PW)) dut (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .enable    (enable),
      .step0     (step0),
      .step1     (step1),
`ifdef SINE_ROM_SCHED_PHASE_OFFSET_EN
      .phase_off1(phase_off1),
`endif
      .rom_en    (rom_en),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .ch0_data  (ch0_data),
      .ch0_valid (ch0_valid),
      .ch1_data  (ch1_data),
      .ch1_valid (ch1_valid),
      .busy      (busy),
      .overrun   (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ROM: word = address, one-cycle latency
   always @(posedge clk) begin
      if (rom_en) rom_data <= {{(DW-AW){1'b0}}, rom_addr};
   end

   always @(negedge clk) begin
      if (rom_en)    n_romen <= n_romen + 1;
      if (ch0_valid) n_v0    <= n_v0 + 1;
      if (ch1_valid) n_v1    <= n_v1 + 1;
      if (busy)      n_busy  <= n_busy + 1;
   end

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs != exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One accepted tick, checked cycle by cycle; mid_chg disturbs inputs after E0.
   task automatic send_tick(input bit mid_chg);
      int a0, a1;
      @(negedge clk);
      tick = 1'b1;
`ifdef SINE_ROM_SCHED_PHASE_OFFSET_EN
      m_off = int'(phase_off1);
`endif
      a0 = m_acc0 >> SH;
      a1 = ((m_acc1 + m_off) & PMASK) >> SH;
      m_acc0 = (m_acc0 + int'(step0)) & PMASK;
      m_acc1 = (m_acc1 + int'(step1)) & PMASK;
      @(negedge clk);
      tick = 1'b0;
      chk("rom_en_e0", rom_en, 1);
      chk("addr0", rom_addr, a0);
      chk("busy_e0", busy, 1);
      if (mid_chg) begin
         enable = 1'b0;
         step0  = 16'($urandom);
         step1  = 16'($urandom);
      end
      @(negedge clk);
      chk("addr1", rom_addr, a1);
      chk("rom_en_e1", rom_en, 1);
      chk("v0_early", ch0_valid, 0);
      if (mid_chg) tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      chk("v0", ch0_valid, 1);
      chk("ch0_data", ch0_data, a0);
      chk("rom_en_e2", rom_en, 0);
      @(negedge clk);
      chk("v1", ch1_valid, 1);
      chk("v0_end", ch0_valid, 0);
      chk("ch1_data", ch1_data, a1);
      @(negedge clk);
      chk("v1_end", ch1_valid, 0);
      chk("busy_end", busy, 0);
      enable = 1'b1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      m_acc0 = 0;
      m_acc1 = 0;
   endtask

   initial begin
      int b_romen, b_v0, b_v1, b_busy;
      rst = 1'b1; tick = 1'b0; enable = 1'b0; step0 = '0; step1 = '0;
`ifdef SINE_ROM_SCHED_PHASE_OFFSET_EN
      phase_off1 = '0;
`endif
      do_reset();
      chk("rst_rom_en", rom_en, 0);
      chk("rst_rom_addr", rom_addr, 0);
      chk("rst_ch0", ch0_data, 0);
      chk("rst_ch1", ch1_data, 0);
      chk("rst_v0", ch0_valid, 0);
      chk("rst_v1", ch1_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ovr", overrun, 0);

      // basic stepping, sparse ticks
      enable = 1'b1; step0 = 16'h0400; step1 = 16'h0800;
      for (int i = 0; i < 3; i++) begin
         send_tick(1'b0);
         repeat (1000) @(negedge clk);
      end
      chk("basic_ch0", ch0_data, 2);
      chk("basic_ch1", ch1_data, 4);

      // full-circle wrap, channel 1 running backwards
      do_reset();
      step0 = 16'h0400; step1 = 16'hFC00;
      for (int i = 0; i < 65; i++) send_tick(1'b0);
      chk("wrap_ch0", ch0_data, 0);
      chk("wrap_ch1", ch1_data, 0);

      // disabled ticks leave everything untouched
      enable = 1'b0;
      @(posedge clk); #1;
      b_romen = n_romen; b_v0 = n_v0; b_v1 = n_v1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); tick = 1'b1;
         @(negedge clk); tick = 1'b0;
         repeat (3) @(negedge clk);
      end
      @(posedge clk); #1;
      chk("dis_romen", n_romen - b_romen, 0);
      chk("dis_v0", n_v0 - b_v0, 0);
      chk("dis_v1", n_v1 - b_v1, 0);
      chk("dis_ovr", overrun, 0);
      enable = 1'b1;
      send_tick(1'b0);

      // randomized traffic
      for (int i = 0; i < 60; i++) begin
         step0 = 16'($urandom);
         step1 = 16'($urandom);
`ifdef SINE_ROM_SCHED_PHASE_OFFSET_EN
         phase_off1 = 16'($urandom);
`endif
         repeat ($urandom_range(0, 5)) @(negedge clk);
         if ($urandom_range(0, 4) == 0) begin
            @(posedge clk); #1;
            b_romen = n_romen;
            @(negedge clk); enable = 1'b0; tick = 1'b1;
            @(negedge clk); tick = 1'b0; enable = 1'b1;
            repeat (4) @(negedge clk);
            @(posedge clk); #1;
            chk("rnd_dis_romen", n_romen - b_romen, 0);
         end else begin
            send_tick(1'($urandom_range(0, 1)));
         end
         chk("rnd_ovr", overrun, 0);
      end

      // overrun: second tick lands on E2
      step0 = 16'h0400; step1 = 16'h0800;
      repeat (3) @(negedge clk);
      @(posedge clk); #1;
      b_v0 = n_v0; b_v1 = n_v1; b_busy = n_busy;
      @(negedge clk); tick = 1'b1;
      m_acc0 = (m_acc0 + 16'h0400) & PMASK;
      m_acc1 = (m_acc1 + 16'h0800) & PMASK;
      @(negedge clk); tick = 1'b0;
      @(negedge clk);
      chk("ovr_pre", overrun, 0);
      tick = 1'b1;
      @(negedge clk); tick = 1'b0;
      chk("ovr_set", overrun, 1);
      chk("ovr_v0", ch0_valid, 1);
      repeat (6) @(negedge clk);
      @(posedge clk); #1;
      chk("ovr_n_v0", n_v0 - b_v0, 1);
      chk("ovr_n_v1", n_v1 - b_v1, 1);
      chk("ovr_busy", n_busy - b_busy, 3);
      send_tick(1'b0);
      chk("ovr_sticky", overrun, 1);

      // reset while in RD1
      @(posedge clk); #1;
      b_v0 = n_v0; b_v1 = n_v1;
      @(negedge clk); tick = 1'b1;
      @(negedge clk); tick = 1'b0;
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      m_acc0 = 0; m_acc1 = 0;
      chk("mid_rst_romen", rom_en, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_v0", ch0_valid, 0);
      chk("mid_rst_ovr", overrun, 0);
      repeat (4) @(negedge clk);
      @(posedge clk); #1;
      chk("mid_rst_n_v0", n_v0 - b_v0, 0);
      chk("mid_rst_n_v1", n_v1 - b_v1, 0);
      send_tick(1'b0);

`ifdef SINE_ROM_SCHED_PHASE_OFFSET_EN
      // quadrature: channel 1 leads by a quarter turn
      do_reset();
      step0 = 16'h0400; step1 = 16'h0400; phase_off1 = 16'h4000;
      for (int i = 0; i < 50; i++) send_tick(1'b0);
      chk("quad_ch0", ch0_data, 49);
      chk("quad_ch1", ch1_data, 1);
`endif

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
